// File: rtl/data_mem_responder_if.sv
// Core data port and host preload port of the data memory responder.
// The master side (core plus host) drives address/data/strobes; the slave
// side (responder) returns load data and preload ready.
interface data_mem_responder_if;
    // core data port
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    // host preload port
    logic        load_valid;
    logic        load_ready;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic        load_last;

    modport master (
        output MemWrite, ALUResult, WriteData,
        output load_valid, load_addr, load_data, load_last,
        input  ReadData, load_ready
    );

    modport slave (
        input  MemWrite, ALUResult, WriteData,
        input  load_valid, load_addr, load_data, load_last,
        output ReadData, load_ready
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data memory responder for the single-cycle core: word RAM with
// combinational reads, host preload phase, and a small MMIO window
// (cycle counter, LED register, DONE doorbell).
module data_mem_responder #(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] MMIO_BASE = 32'h0000_0400
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus,
    output logic                 start,
    output logic                 done,
    output logic [7:0]           leds,
    output logic [31:0]          cycle_count
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] S_LOAD = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    logic [1:0]  state;
    logic [31:0] mem [DEPTH];

    // RAM region: every bit above the word index must be zero
    function automatic logic in_ram(input logic [31:0] a);
        return a[31:AW+2] == '0;
    endfunction

    // 16-byte MMIO window
    function automatic logic in_mmio(input logic [31:0] a);
        return a[31:4] == MMIO_BASE[31:4];
    endfunction

    logic          ld_acc;
    logic          core_wr;
    logic          mmio_wr;
    logic          led_we;
    logic          done_we;
    logic          ram_we;
    logic [AW-1:0] ram_wa;
    logic [31:0]   ram_wd;
    logic [1:0]    core_off;

    // byte-lane bits of both addresses are don't-care
    logic [3:0] unused_lsbs;
    assign unused_lsbs = {bus.ALUResult[1:0], bus.load_addr[1:0]};

    // ready is forced low while reset is asserted so a beat at a reset edge is never taken
    assign bus.load_ready = (state == S_LOAD) && reset;
    assign start          = (state == S_RUN);
    assign done           = (state == S_HALT);

    assign ld_acc   = bus.load_valid && bus.load_ready;
    assign core_wr  = bus.MemWrite && (state == S_RUN);
    assign core_off = bus.ALUResult[3:2];
    assign mmio_wr  = core_wr && in_mmio(bus.ALUResult);
    assign led_we   = mmio_wr && (core_off == 2'd1);
    assign done_we  = mmio_wr && (core_off == 2'd2);

    // preload owns the RAM write port in LOAD, the core owns it in RUN
    assign ram_we = reset && ((ld_acc && in_ram(bus.load_addr)) ||
                              (core_wr && in_ram(bus.ALUResult)));
    assign ram_wa = (state == S_LOAD) ? bus.load_addr[AW+1:2] : bus.ALUResult[AW+1:2];
    assign ram_wd = (state == S_LOAD) ? bus.load_data : bus.WriteData;

    // run-phase sequencing: LOAD -> RUN on last beat, RUN -> HALT on doorbell
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_LOAD;
        end else begin
            case (state)
                S_LOAD:  if (ld_acc && bus.load_last) state <= S_RUN;
                S_RUN:   if (done_we) state <= S_HALT;
                S_HALT:  state <= S_HALT;
                default: state <= S_LOAD;
            endcase
        end
    end

    // saturating RUN-cycle counter; the doorbell edge itself is not counted
    always_ff @(posedge clk) begin
        if (!reset) begin
            cycle_count <= '0;
        end else if (state == S_RUN && !done_we && cycle_count != 32'hFFFF_FFFF) begin
            cycle_count <= cycle_count + 32'd1;
        end
    end

    // LED register, writable only while running
    always_ff @(posedge clk) begin
        if (!reset) begin
            leds <= '0;
        end else if (led_we) begin
            leds <= bus.WriteData[7:0];
        end
    end

    // RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_wa] <= ram_wd;
        end
    end

    // zero-latency read mux: RAM, MMIO window, else zero
    always_comb begin
        bus.ReadData = '0;
        if (in_ram(bus.ALUResult)) begin
            bus.ReadData = mem[bus.ALUResult[AW+1:2]];
        end else if (in_mmio(bus.ALUResult)) begin
            case (core_off)
                2'd0:    bus.ReadData = cycle_count;
                2'd1:    bus.ReadData = {24'b0, leds};
                2'd2:    bus.ReadData = {31'b0, done};
                default: bus.ReadData = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: stimulus pushes expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_data_mem_responder;
    localparam int          DEPTH = 128;   // RAM 0x000-0x1FF, gap up to MMIO
    localparam logic [31:0] MB    = 32'h0000_0400;

    localparam int K_RD    = 0;
    localparam int K_LR    = 1;
    localparam int K_START = 2;
    localparam int K_DONE  = 3;
    localparam int K_LEDS  = 4;
    localparam int K_CC    = 5;

    typedef struct {
        int          kind;
        logic [31:0] v;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic        done;
    logic [7:0]  leds;
    logic [31:0] cycle_count;

    data_mem_responder_if bus ();

    data_mem_responder #(.DEPTH(DEPTH), .MMIO_BASE(MB)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .start       (start),
        .done        (done),
        .leds        (leds),
        .cycle_count (cycle_count)
    );

    exp_t        q[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_cc = 0;
    bit          in_run = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic string kname(input int k);
        case (k)
            K_RD:    return "ReadData";
            K_LR:    return "load_ready";
            K_START: return "start";
            K_DONE:  return "done";
            K_LEDS:  return "leds";
            default: return "cycle_count";
        endcase
    endfunction

    function automatic logic [31:0] actual(input int k);
        case (k)
            K_RD:    return bus.ReadData;
            K_LR:    return {31'b0, bus.load_ready};
            K_START: return {31'b0, start};
            K_DONE:  return {31'b0, done};
            K_LEDS:  return {24'b0, leds};
            default: return cycle_count;
        endcase
    endfunction

    // monitor: drain this cycle's expectations on the falling edge
    always @(negedge clk) begin
        while (q.size() != 0) begin
            exp_t e;
            logic [31:0] a;
            e = q.pop_front();
            a = actual(e.kind);
            total++;
            if (a !== e.v) begin
                bad++;
                $display("FAIL %s at %0t: got %h want %h (ALUResult=%h)",
                         kname(e.kind), $time, a, e.v, bus.ALUResult);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic expect_v(input int k, input logic [31:0] v);
        exp_t e;
        e.kind = k;
        e.v    = v;
        q.push_back(e);
    endtask

    // expected counter follows the cycle the edge closes
    task automatic step();
        if (!reset) exp_cc = 0;
        else if (in_run && exp_cc != 32'hFFFF_FFFF) exp_cc = exp_cc + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.MemWrite   = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] v);
        bus.MemWrite  = 1'b0;
        bus.ALUResult = a;
        expect_v(K_RD, v);
        expect_v(K_CC, exp_cc);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.MemWrite  = 1'b1;
        bus.ALUResult = a;
        bus.WriteData = d;
    endtask

    task automatic beat(input logic [31:0] a, input logic [31:0] d, input logic last);
        bus.load_valid = 1'b1;
        bus.load_addr  = a;
        bus.load_data  = d;
        bus.load_last  = last;
    endtask

    initial begin
        reset = 1'b0;
        bus.MemWrite = 0; bus.ALUResult = 0; bus.WriteData = 0;
        bus.load_valid = 0; bus.load_addr = 0; bus.load_data = 0; bus.load_last = 0;

        // reset state, reset still held
        step();
        expect_v(K_LR, 0); expect_v(K_START, 0); expect_v(K_DONE, 0);
        expect_v(K_LEDS, 0); expect_v(K_CC, 0);
        step();

        // preload 0/4/8 = 11/22/33, core write in LOAD must be ignored
        reset = 1'b1;
        expect_v(K_LR, 1); expect_v(K_START, 0);
        beat(32'h0, 32'd11, 1'b0);
        step();
        expect_v(K_LR, 1);
        beat(32'h4, 32'd22, 1'b0);
        step();
        expect_v(K_LR, 1); expect_v(K_START, 0);
        beat(32'h8, 32'd33, 1'b1);
        wr(32'h4, 32'h77);
        step();
        in_run = 1;
        idle();

        // first RUN cycle
        expect_v(K_START, 1); expect_v(K_LR, 0);
        rd(32'h4, 32'd22);
        step();
        rd(32'h0, 32'd11);        step();
        rd(32'h8, 32'd33);        step();

        // RAM store, unmapped store, gap/high reads
        wr(32'h10, 32'hDEAD_BEEF);  step();
        rd(32'h10, 32'hDEAD_BEEF);  step();
        wr(32'h100, 32'hCAFE_0001); step();
        wr(32'h300, 32'h1234_5678); step();
        rd(32'h100, 32'hCAFE_0001); step();
        rd(32'h300, 32'h0);         step();
        rd(32'h3F0, 32'h0);         step();
        rd(32'h410, 32'h0);         step();

        // MMIO: LED write, read-only counter, reserved slot, doorbell readback
        wr(MB + 4, 32'h1A5);        step();
        rd(MB + 4, 32'hA5);
        expect_v(K_LEDS, 32'hA5);   step();
        wr(MB + 0, 32'hFFFF);       step();
        rd(MB + 0, exp_cc);         step();
        wr(MB + 12, 32'h5);         step();
        rd(MB + 12, 32'h0);         step();
        rd(MB + 8, 32'h0);          step();

        // reset mid-RUN with a store at the reset edge
        reset = 1'b0;
        wr(32'h10, 32'h0BAD);
        step();
        in_run = 0;
        bus.MemWrite = 1'b0;
        expect_v(K_LR, 0); expect_v(K_START, 0); expect_v(K_DONE, 0);
        expect_v(K_LEDS, 0); expect_v(K_CC, 0);
        step();
        reset = 1'b1;
        expect_v(K_LR, 1);
        rd(32'h10, 32'hDEAD_BEEF);

        // out-of-range last beat (aliases word 0 if wrongly written)
        beat(32'h800, 32'h5555, 1'b1);
        step();
        in_run = 1;
        idle();
        expect_v(K_START, 1);
        rd(32'h0, 32'd11);
        step();
        while (exp_cc < 10) begin
            expect_v(K_CC, exp_cc);
            expect_v(K_START, 1);
            step();
        end

        // doorbell with counter at 10
        wr(MB + 8, 32'h1);
        in_run = 0;
        expect_v(K_CC, 32'd10);
        step();
        expect_v(K_DONE, 1); expect_v(K_START, 0); expect_v(K_LR, 0);
        expect_v(K_CC, 32'd10);
        wr(32'h0, 32'h99);
        step();
        rd(32'h0, 32'd11);
        expect_v(K_DONE, 1);
        step();
        wr(MB + 4, 32'hFF);
        step();
        expect_v(K_LEDS, 0);
        rd(MB + 8, 32'h1);
        step();

        idle();
        @(negedge clk);
        #1;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL final done: got %b want 1", done);
        end
        if (start !== 1'b0) begin
            bad++;
            $display("FAIL final start: got %b want 0", start);
        end
        if (cycle_count !== 32'd10) begin
            bad++;
            $display("FAIL final cycle_count: got %0d want 10", cycle_count);
        end
        if (leds !== 8'h00) begin
            bad++;
            $display("FAIL final leds: got %h want 00", leds);
        end
        if (bus.load_ready !== 1'b0) begin
            bad++;
            $display("FAIL final load_ready: got %b want 0", bus.load_ready);
        end
        if (total < 12) begin
            bad++;
            $display("FAIL too few checks: %0d", total);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        if (bad != 0) $display("FAIL");
        else $display("PASS");
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the single-cycle `arm` core's data port: serves combinational `ReadData` for `ALUResult` and commits `WriteData` on `MemWrite`. It also contains a host preload port that fills data RAM while the core is held idle, then drives the core's `start` input. A small MMIO window provides a cycle counter, an LED register and a DONE doorbell that halts the run. It sits between the `arm` top-level data interface and the board/host logic.

## Interface
- `DEPTH`, 256: data RAM size in 32-bit words; power of two, ≥ 4.
- `MMIO_BASE`, 32'h0000_0400: byte base of the MMIO window; must be ≥ `DEPTH*4`, 16-byte aligned.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low; sampled on rising `clk`.
- `MemWrite`  in  1  core write strobe.
- `ALUResult`  in  32  core byte address; bits [1:0] ignored.
- `WriteData`  in  32  core store data.
- `ReadData`  out  32  load data, combinational from address/state.
- `load_valid`  in  1  host preload beat valid.
- `load_ready`  out  1  responder accepts a preload beat.
- `load_addr`  in  32  preload byte address; bits [1:0] ignored.
- `load_data`  in  32  preload word.
- `load_last`  in  1  marks the final preload beat.
- `start`  out  1  run enable to the core.
- `done`  out  1  run finished; held until reset.
- `leds`  out  8  LED register contents.
- `cycle_count`  out  32  RUN-cycle counter.

## Operation
- States: LOAD, RUN, HALT. On reset: LOAD. Reset values: `start`=0, `done`=0, `load_ready`=0 in the reset cycle, then 1 in LOAD. `leds`=0 and `cycle_count`=0. RAM contents are not cleared.
- Word index = `addr[log2(DEPTH)+1:2]`. RAM region = byte address < `DEPTH*4`.
- LOAD:
  - `load_ready`=1.
  - A beat is accepted when `load_valid && load_ready`; it writes `load_data` to RAM if `load_addr` is in the RAM region. Otherwise the beat is accepted and dropped.
  - An accepted beat with `load_last`=1 writes that word and moves to RUN on the same edge.
  - Core `MemWrite` is ignored.
- RUN:
  - `start`=1, `load_ready`=0.
  - `cycle_count` increments every cycle and saturates at 32'hFFFF_FFFF.
  - A RAM write with `MemWrite`=1 and an in-range address commits `WriteData` on the edge.
- MMIO (byte offsets from `MMIO_BASE`):
  - +0: `cycle_count`, read-only; writes are ignored.
  - +4: LED register; read returns {24'b0, `leds`}; write takes `WriteData[7:0]`.
  - +8: DONE doorbell; read returns {31'b0, `done`}; any write moves to HALT.
  - +12: reads 0, writes ignored.
- `ReadData`:
  - RAM word for in-range addresses.
  - MMIO value for addresses inside the window.
  - 0 everywhere else, including addresses between RAM end and `MMIO_BASE` and above `MMIO_BASE+15`.
  - Valid in every state.
- HALT: `start`=0, `done`=1, `load_ready`=0, `cycle_count` frozen. All core writes are ignored, including RAM and LED writes. HALT is left only by reset.

## Timing
- Reads have zero latency: combinational, no register stage, so the single-cycle core loads in the same cycle.
- RAM and MMIO writes become visible to a read in the cycle after the write edge.
- `start` rises in the cycle after the edge that accepts the `load_last` beat. `cycle_count` reads 0 in that first RUN cycle and 1 in the next.
- DONE write at edge N: from N onward `start`=0 and `done`=1; `cycle_count` keeps the value it had before edge N (no increment at N).
- Reset low at any edge, mid-LOAD or mid-RUN: the next state is LOAD with all outputs at reset values. A preload beat or core write presented at that edge is discarded.
- Write to a read-only or unmapped address in RUN: no state change other than the normal counter increment.

## Test plan
- Reset, then preload 3 beats (addr 0, 4, 8; data 11, 22, 33; last on the third) -> `load_ready`=1 throughout LOAD, `start`=1 the next cycle, `ReadData`=22 for `ALUResult`=4.
- In RUN, `MemWrite`=1, `ALUResult`=0x10, `WriteData`=0xDEADBEEF -> `ReadData`=0xDEADBEEF at 0x10 from the next cycle; the same write with address 0x300 (unmapped) -> `ReadData` at 0x300 stays 0 and RAM is unchanged.
- Write 0x1A5 to `MMIO_BASE+4` -> `leds`=8'hA5, read returns 0x000000A5. Write to `MMIO_BASE+0` -> counter unaffected.
- Run 10 cycles, then write `MMIO_BASE+8` -> `done`=1, `start`=0, `cycle_count`=10 and held; a subsequent RAM write is ignored.
- Assert reset low mid-RUN with `MemWrite`=1 -> write discarded, state LOAD, `cycle_count`=0, `leds`=0, `done`=0.
- Preload beat with `load_addr`=0x800 and `load_last`=1 -> beat accepted and dropped, transition to RUN still occurs.
